// File: rtl/enigma_pkg.sv
// Shared constants, rotor/reflector tables, modular helpers and FSM state type
// for enigma_rotor_engine.
package enigma_pkg;
    localparam int         ALPHA   = 26;
    localparam logic [7:0] ASCII_A = 8'h41;

    // Tables are ASCII strings; the first character is symbol 0 ('A').
    typedef logic [ALPHA*8-1:0] table_t;

    localparam table_t WIRE_FWD [4] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB"
    };

    localparam table_t WIRE_INV [4] = '{
        "UWYGADFPVZBECKMTHXSLRINQOJ",
        "AJPCZWRLFBDKOTYUQGENHXMIVS",
        "TAGBPCSDQEUFVNZHYIXJWLRKOM",
        "HZWVARTNLGUPXQCEJMBSKDYOIF"
    };

    localparam table_t REFL_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    // Turnover positions for rotors I..IV: Q, E, V, J.
    localparam logic [4:0] NOTCH [4] = '{5'd16, 5'd4, 5'd21, 5'd9};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_FWD,
        ST_REFL,
        ST_BWD,
        ST_OUT
    } state_t;

    function automatic logic [4:0] tbl_lookup(input table_t t, input logic [4:0] idx);
        logic [7:0] ch;
        ch = t[(ALPHA - 1 - int'(idx)) * 8 +: 8];
        return 5'(ch - ASCII_A);
    endfunction

    function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
        return s[4:0];
    endfunction

    // A negative 6-bit difference shows up as bit 5 set; adding 26 wraps it back.
    function automatic logic [4:0] sub_mod(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[5]) d = d + 6'(ALPHA);
        return d[4:0];
    endfunction

    function automatic logic [4:0] norm_pos(input logic [4:0] p);
        return (p >= 5'(ALPHA)) ? 5'(p - 5'(ALPHA)) : p;
    endfunction
endpackage

// File: rtl/enigma_rotor_map.sv
// One rotor pass: offsets the symbol by the rotor position, applies the forward
// (dir=0) or inverse (dir=1) wiring, and removes the offset again.
module enigma_rotor_map
    import enigma_pkg::*;
(
    input  logic [4:0] sym,
    input  logic [1:0] sel,
    input  logic [4:0] pos,
    input  logic       dir,
    output logic [4:0] mapped
);
    logic [4:0] entry;
    logic [4:0] wired;

    always_comb begin
        entry  = add_mod(sym, pos);
        wired  = dir ? tbl_lookup(WIRE_INV[sel], entry) : tbl_lookup(WIRE_FWD[sel], entry);
        mapped = sub_mod(wired, pos);
    end
endmodule

// File: rtl/enigma_rotor_engine.sv
// Sequential Enigma engine: one character in flight, rotors stepped then walked
// forward, reflected and walked back through a single shared rotor map.
// Define ENIGMA_DOUBLE_STEP_EN for the historic middle-rotor double-step anomaly.
module enigma_rotor_engine
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int CHAR_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHAR_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHAR_W-1:0]       out_data,
    input  logic                    cfg_load,
    input  logic [2*NUM_ROTORS-1:0] cfg_sel,
    input  logic [5*NUM_ROTORS-1:0] cfg_pos,
    output logic [5*NUM_ROTORS-1:0] pos_out
);
    localparam logic [2:0]        LAST_SLOT = 3'(NUM_ROTORS - 1);
    localparam logic [CHAR_W-1:0] CH_A      = CHAR_W'(ASCII_A);
    localparam logic [CHAR_W-1:0] CH_Z      = CHAR_W'(ASCII_A + 8'd25);

    state_t                  state, state_nxt;
    logic [2:0]              slot;
    logic [4:0]              sym;
    logic [5*NUM_ROTORS-1:0] pos_q;
    logic [2*NUM_ROTORS-1:0] sel_q;
    logic                    accept;
    logic                    is_letter;
    logic [NUM_ROTORS-1:0]   at_notch;
    logic [NUM_ROTORS-1:0]   adv;
    logic [5*NUM_ROTORS-1:0] pos_stepped;
    logic [4:0]              map_out;

    assign is_letter = (in_data >= CH_A) && (in_data <= CH_Z);
    assign pos_out   = pos_q;

    enigma_rotor_map u_map (
        .sym    (sym),
        .sel    (sel_q[int'(slot)*2 +: 2]),
        .pos    (pos_q[int'(slot)*5 +: 5]),
        .dir    (state == ST_BWD),
        .mapped (map_out)
    );

    // Odometer carry: a slot moves only when its right neighbour moves off its notch.
    always_comb begin
        adv         = '0;
        adv[0]      = 1'b1;
        at_notch    = '0;
        pos_stepped = pos_q;
        for (int k = 0; k < NUM_ROTORS; k++)
            at_notch[k] = (pos_q[k*5 +: 5] == NOTCH[sel_q[k*2 +: 2]]);
        for (int k = 1; k < NUM_ROTORS; k++) begin
            adv[k] = adv[k-1] & at_notch[k-1];
`ifdef ENIGMA_DOUBLE_STEP_EN
            if (k < NUM_ROTORS - 1) adv[k] = adv[k] | at_notch[k];
`endif
        end
        for (int k = 0; k < NUM_ROTORS; k++)
            if (adv[k])
                pos_stepped[k*5 +: 5] = (pos_q[k*5 +: 5] == 5'd25) ? 5'd0 : pos_q[k*5 +: 5] + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = rst_n && (state == ST_IDLE) && !cfg_load;
        out_valid = (state == ST_OUT);
        accept    = in_valid && in_ready;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_letter ? ST_STEP : ST_OUT;
            ST_STEP: state_nxt = ST_FWD;
            ST_FWD:  if (slot == LAST_SLOT) state_nxt = ST_REFL;
            ST_REFL: state_nxt = ST_BWD;
            ST_BWD:  if (slot == 3'd0) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: rotor positions and selections are plain flops, reset explicitly so an
    // aborted character leaves the rotors back at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= '0;
            sym      <= '0;
            pos_q    <= '0;
            sel_q    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        sel_q <= cfg_sel;
                        for (int k = 0; k < NUM_ROTORS; k++)
                            pos_q[k*5 +: 5] <= norm_pos(cfg_pos[k*5 +: 5]);
                    end
                    if (accept) begin
                        if (is_letter) sym      <= 5'(in_data - CH_A);
                        else           out_data <= in_data;
                    end
                end
                ST_STEP: begin
                    pos_q <= pos_stepped;
                    slot  <= '0;
                end
                ST_FWD: begin
                    sym <= map_out;
                    if (slot != LAST_SLOT) slot <= slot + 3'd1;
                end
                ST_REFL: sym <= tbl_lookup(REFL_B, sym);
                ST_BWD: begin
                    sym <= map_out;
                    if (slot == 3'd0) out_data <= CHAR_W'(ASCII_A + {3'b000, map_out});
                    else              slot     <= slot - 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_enigma_rotor_engine.sv
// Directed bench for enigma_rotor_engine (NUM_ROTORS=3) with hand-derived vectors.
module tb_enigma_rotor_engine;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, out_valid, out_ready, cfg_load;
    logic [7:0]     in_data, out_data;
    logic [2*N-1:0] cfg_sel;
    logic [5*N-1:0] cfg_pos, pos_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    localparam logic [5:0] SEL_STD = {2'd0, 2'd1, 2'd2};  // slot2/1/0 = I/II/III

    enigma_rotor_engine #(.NUM_ROTORS(N), .CHAR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_load  (cfg_load),
        .cfg_sel   (cfg_sel),
        .cfg_pos   (cfg_pos),
        .pos_out   (pos_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [14:0] pos3(input int l, input int m, input int r);
        return {5'(l), 5'(m), 5'(r)};
    endfunction

    task automatic load_cfg(input logic [5:0] s, input logic [14:0] p);
        @(negedge clk);
        cfg_load = 1'b1; cfg_sel = s; cfg_pos = p;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Returns at the negedge of the first cycle after the accepting edge (cyc = 1).
    task automatic start_char(input logic [7:0] c);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = c;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_out(output logic [7:0] got, output int lat);
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        got = out_data;
    endtask

    task automatic send(input logic [7:0] c, output logic [7:0] got, output int lat);
        start_char(c);
        wait_out(got, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  got;
        int          lat;
        string       plain, cipher, back;
        logic [14:0] step_exp [3];

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_load = 1'b0; cfg_sel = '0; cfg_pos = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_pos_out",   32'(pos_out),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Basic encipherment
        plain = "AAAAA"; cipher = "BDZGO";
        load_cfg(SEL_STD, pos3(0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            send(plain[i], got, lat);
            check($sformatf("enc_%0d", i), 32'(got), 32'(cipher[i]));
        end
        check("enc_latency", 32'(lat), 32'd9);
        check("enc_pos_AAF", 32'(pos_out), 32'(pos3(0, 0, 5)));

        // Reciprocity
        back = "AAAAA";
        load_cfg(SEL_STD, pos3(0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            send(cipher[i], got, lat);
            check($sformatf("dec_%0d", i), 32'(got), 32'(back[i]));
        end

        // Pass-through of non-letters
        send(8'h20, got, lat);
        check("pass_space",     32'(got), 32'h20);
        check("pass_space_lat", 32'(lat), 32'd1);
        send(8'h37, got, lat);
        check("pass_7",         32'(got), 32'h37);
        check("pass_7_lat",     32'(lat), 32'd1);
        check("pass_pos_kept",  32'(pos_out), 32'(pos3(0, 0, 5)));

        // Stepping from A,D,U
`ifdef ENIGMA_DOUBLE_STEP_EN
        step_exp = '{pos3(0, 3, 21), pos3(0, 4, 22), pos3(1, 5, 23)};
`else
        step_exp = '{pos3(0, 3, 21), pos3(0, 4, 22), pos3(0, 4, 23)};
`endif
        load_cfg(SEL_STD, pos3(0, 3, 20));
        for (int i = 0; i < 3; i++) begin
            send(8'h41, got, lat);
            check($sformatf("step_%0d", i), 32'(pos_out), 32'(step_exp[i]));
        end

        // Out-of-range start positions fold back by 26
        load_cfg(SEL_STD, pos3(27, 30, 31));
        check("cfg_pos_wrap", 32'(pos_out), 32'(pos3(1, 4, 5)));

        // cfg_load in IDLE blocks input acceptance
        @(negedge clk);
        cfg_load = 1'b1; cfg_sel = SEL_STD; cfg_pos = pos3(0, 0, 0);
        #1 check("cfg_blocks_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        cfg_load = 1'b0;

        // Backpressure and letter latency
        out_ready = 1'b0;
        start_char(8'h41);
        wait_out(got, lat);
        check("bp_latency", 32'(lat), 32'd9);
        check("bp_data",    32'(got), 32'h42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_data_%0d", i),  32'(out_data),  32'h42);
            check($sformatf("bp_in_ready_%0d", i),   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);

        // Reset during FWD aborts the character
        load_cfg(SEL_STD, pos3(0, 0, 0));
        start_char(8'h41);
        @(negedge clk);
        check("pre_rst_pos", 32'(pos_out), 32'(pos3(0, 0, 1)));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pos",       32'(pos_out),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_no_output", 32'(out_valid), 32'd0);

        // cfg_load during BWD is ignored
        load_cfg(SEL_STD, pos3(0, 0, 0));
        start_char(8'h41);
        repeat (5) begin
            @(negedge clk);
            cyc++;
        end
        cfg_load = 1'b1; cfg_sel = 6'b111111; cfg_pos = pos3(7, 7, 7);
        @(negedge clk);
        cyc++;
        cfg_load = 1'b0;
        wait_out(got, lat);
        check("guard_latency", 32'(lat),     32'd9);
        check("guard_data",    32'(got),     32'h42);
        check("guard_pos",     32'(pos_out), 32'(pos3(0, 0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
